// File: rtl/graphite_vram_pkg.sv
// Shared VRAM bus widths, request payload and arbiter state encoding.
package graphite_vram_pkg;

  localparam int unsigned VRAM_ADDR_W = 32;
  localparam int unsigned VRAM_DATA_W = 16;
  localparam int unsigned VRAM_MASK_W = 4;

  // One VRAM transaction as presented downstream.
  typedef struct packed {
    logic                   wr;
    logic [VRAM_MASK_W-1:0] mask;
    logic [VRAM_ADDR_W-1:0] addr;
    logic [VRAM_DATA_W-1:0] data;
  } vram_req_t;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// Requester-side and VRAM-side signals of the arbiter.
// Signal suffixes are from the arbiter's point of view (_i into the arbiter, _o out of it).
//   req_*   : NUM_REQ requesters, packed side by side (requester g at slice g)
//   vram_*  : single downstream VRAM/SDRAM controller port
// slave  : arbiter view
// master : environment view (requesters + VRAM controller)
interface vram_arbiter_if
  import graphite_vram_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
);

  logic [NUM_REQ-1:0]             req_sel_i;
  logic [NUM_REQ-1:0]             req_wr_i;
  logic [NUM_REQ*VRAM_MASK_W-1:0] req_mask_i;
  logic [NUM_REQ*VRAM_ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ*VRAM_DATA_W-1:0] req_data_out_i;
  logic [NUM_REQ-1:0]             req_ack_o;
  logic [VRAM_DATA_W-1:0]         req_data_in_o;

  logic                           vram_ack_i;
  logic [VRAM_DATA_W-1:0]         vram_data_in_i;
  logic                           vram_sel_o;
  logic                           vram_wr_o;
  logic [VRAM_MASK_W-1:0]         vram_mask_o;
  logic [VRAM_ADDR_W-1:0]         vram_addr_o;
  logic [VRAM_DATA_W-1:0]         vram_data_out_o;

  modport slave (
    input  req_sel_i, req_wr_i, req_mask_i, req_addr_i, req_data_out_i,
    output req_ack_o, req_data_in_o,
    input  vram_ack_i, vram_data_in_i,
    output vram_sel_o, vram_wr_o, vram_mask_o, vram_addr_o, vram_data_out_o
  );

  modport master (
    output req_sel_i, req_wr_i, req_mask_i, req_addr_i, req_data_out_i,
    input  req_ack_o, req_data_in_o,
    output vram_ack_i, vram_data_in_i,
    input  vram_sel_o, vram_wr_o, vram_mask_o, vram_addr_o, vram_data_out_o
  );

endinterface

// File: rtl/rr_picker.sv
// Rotating-priority encoder: picks the first set req bit starting just after
// last_i and wrapping, so the last winner has lowest priority.
//   req_i      : request vector
//   last_i     : index of the previous winner
//   valid_c    : any request present
//   winner_c   : chosen index (equals last_i when nothing is requested)
module rr_picker #(
  parameter  int unsigned N     = 2,
  localparam int unsigned PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] last_i,
  output logic             valid_c,
  output logic [PTR_W-1:0] winner_c
);

  logic [PTR_W-1:0] idx;
  logic             found;

  // Walk offsets 1..N from the last winner; offset N wraps back onto last_i itself.
  always_comb begin
    idx      = last_i;
    found    = 1'b0;
    winner_c = last_i;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = PTR_W'((32'(last_i) + i) % N);
      if (!found && req_i[idx]) begin
        found    = 1'b1;
        winner_c = idx;
      end
    end
    valid_c = found;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Round-robin arbiter sharing one VRAM port between NUM_REQ requesters.
// The winning request is registered onto vram_*_o and held until vram_ack_i.
//   clk, reset_ni : clock, asynchronous active-low reset
//   bus           : requester and VRAM signals (slave modport)
//   grant_o       : index of the last or current grant
//   busy_o        : a transaction is outstanding downstream
// req_ack_o and req_data_in_o are combinational so a requester sees its ack in
// the same cycle as vram_ack_i.
module vram_arbiter
  import graphite_vram_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset_ni,
  vram_arbiter_if.slave        bus,
  output logic [PTR_W-1:0]     grant_o,
  output logic                 busy_o
);

  arb_state_e       state_q, state_d;
  logic [PTR_W-1:0] grant_q, grant_d;
  logic             sel_q,   sel_d;
  vram_req_t        req_q,   req_d;

  vram_req_t        cand [NUM_REQ];
  logic             pick_valid_c;
  logic [PTR_W-1:0] pick_idx_c;
  logic [NUM_REQ-1:0] req_ack_c;

  // Unpack the per-requester payloads into structs.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cand
    assign cand[g] = '{
      wr:   bus.req_wr_i[g],
      mask: bus.req_mask_i[g*VRAM_MASK_W +: VRAM_MASK_W],
      addr: bus.req_addr_i[g*VRAM_ADDR_W +: VRAM_ADDR_W],
      data: bus.req_data_out_i[g*VRAM_DATA_W +: VRAM_DATA_W]
    };
  end

  rr_picker #(.N(NUM_REQ)) u_picker (
    .req_i    (bus.req_sel_i),
    .last_i   (grant_q),
    .valid_c  (pick_valid_c),
    .winner_c (pick_idx_c)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ARB_IDLE;
      grant_q <= PTR_W'(NUM_REQ - 1);
      sel_q   <= 1'b0;
      req_q   <= '{wr: 1'b0, mask: '1, addr: '0, data: '0};
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      req_q   <= req_d;
    end
  end

  // Next-state: latch the winner in IDLE, hold everything until ack in BUSY.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    req_d   = req_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid_c) begin
          req_d   = cand[pick_idx_c];
          grant_d = pick_idx_c;
          sel_d   = 1'b1;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (bus.vram_ack_i) begin
          sel_d    = 1'b0;
          req_d.wr = 1'b0;
          state_d  = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Ack demux: only the granted requester, and only while a transaction is open.
  always_comb begin
    req_ack_c = '0;
    for (int unsigned g = 0; g < NUM_REQ; g++) begin
      req_ack_c[g] = bus.vram_ack_i && (state_q == ARB_BUSY) && (grant_q == PTR_W'(g));
    end
  end

  assign bus.req_ack_o       = req_ack_c;
  assign bus.req_data_in_o   = bus.vram_data_in_i;
  assign bus.vram_sel_o      = sel_q;
  assign bus.vram_wr_o       = req_q.wr;
  assign bus.vram_mask_o     = req_q.mask;
  assign bus.vram_addr_o     = req_q.addr;
  assign bus.vram_data_out_o = req_q.data;
  assign grant_o             = grant_q;
  assign busy_o              = (state_q == ARB_BUSY);

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a queue of expected grants/payloads.
module tb_vram_arbiter;
  import graphite_vram_pkg::*;

  localparam int unsigned NUM_REQ = 2;

  typedef struct {
    int        g;
    vram_req_t r;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_ni;
  logic [0:0] grant_o;
  logic       busy_o;

  int vectors     = 0;
  int miscompares = 0;
  exp_t exp_q[$];
  exp_t last_exp;
  int   wr_cnt;

  vram_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  vram_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk      (clk),
    .reset_ni (reset_ni),
    .bus      (bus),
    .grant_o  (grant_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic wr, input logic [3:0] mask,
                         input logic [31:0] addr, input logic [15:0] data);
    bus.req_wr_i[i]               = wr;
    bus.req_mask_i[i*4 +: 4]      = mask;
    bus.req_addr_i[i*32 +: 32]    = addr;
    bus.req_data_out_i[i*16 +: 16] = data;
  endtask

  task automatic push(input int g, input logic wr, input logic [3:0] mask,
                      input logic [31:0] addr, input logic [15:0] data);
    exp_t e;
    e.g = g;
    e.r = '{wr: wr, mask: mask, addr: addr, data: data};
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for vram_sel_o, then compare the presented request to the scoreboard.
  task automatic wait_grant(input string tag, input int budget);
    int n = 0;
    while (!bus.vram_sel_o && n < budget) begin
      tick();
      n++;
    end
    if (!bus.vram_sel_o) begin
      vectors++;
      miscompares++;
      $error("FAIL %s_timeout observed=no_grant expected=grant_within_%0d", tag, budget);
    end
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s_sb observed=grant expected=empty_scoreboard", tag);
      return;
    end
    last_exp = exp_q.pop_front();
    check({tag, "_grant"}, 64'(grant_o), 64'(last_exp.g));
    check({tag, "_busy"},  64'(busy_o), 64'd1);
    check({tag, "_wr"},    64'(bus.vram_wr_o), 64'(last_exp.r.wr));
    check({tag, "_mask"},  64'(bus.vram_mask_o), 64'(last_exp.r.mask));
    check({tag, "_addr"},  64'(bus.vram_addr_o), 64'(last_exp.r.addr));
    check({tag, "_data"},  64'(bus.vram_data_out_o), 64'(last_exp.r.data));
  endtask

  // Called in busy cycle 1; acks in busy cycle n, then checks the ack pulse and the idle gap.
  task automatic run_txn(input string tag, input int n, input logic [15:0] rdata,
                         input logic [1:0] exp_ack, input logic [1:0] drop,
                         output int wrc);
    wrc = 0;
    for (int c = 1; c <= n; c++) begin
      if (c > 1) tick();
      if (bus.vram_wr_o) wrc++;
      if (c < n) check({tag, "_ack_early"}, 64'(bus.req_ack_o), 64'd0);
    end
    bus.vram_ack_i     = 1'b1;
    bus.vram_data_in_i = rdata;
    #1;
    check({tag, "_ack"},     64'(bus.req_ack_o), 64'(exp_ack));
    check({tag, "_rdata"},   64'(bus.req_data_in_o), 64'(rdata));
    check({tag, "_hold"},    64'(bus.vram_addr_o), 64'(last_exp.r.addr));
    check({tag, "_holdmask"}, 64'(bus.vram_mask_o), 64'(last_exp.r.mask));
    tick();
    bus.vram_ack_i     = 1'b0;
    bus.vram_data_in_i = 16'h0;
    bus.req_sel_i      = bus.req_sel_i & ~drop;
    #1;
    check({tag, "_ack_end"}, 64'(bus.req_ack_o), 64'd0);
    check({tag, "_gap_sel"}, 64'(bus.vram_sel_o), 64'd0);
    check({tag, "_gap_wr"},  64'(bus.vram_wr_o), 64'd0);
    check({tag, "_idle"},    64'(busy_o), 64'd0);
  endtask

  initial begin
    // 1: reset held with random inputs
    reset_ni = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus.req_sel_i      = 2'($urandom);
      bus.req_wr_i       = 2'($urandom);
      bus.req_mask_i     = 8'($urandom);
      bus.req_addr_i     = {$urandom, $urandom};
      bus.req_data_out_i = $urandom;
      bus.vram_ack_i     = 1'($urandom);
      bus.vram_data_in_i = 16'($urandom);
      tick();
      check("rst_sel",   64'(bus.vram_sel_o), 64'd0);
      check("rst_wr",    64'(bus.vram_wr_o), 64'd0);
      check("rst_mask",  64'(bus.vram_mask_o), 64'hF);
      check("rst_addr",  64'(bus.vram_addr_o), 64'd0);
      check("rst_grant", 64'(grant_o), 64'(NUM_REQ - 1));
      check("rst_ack",   64'(bus.req_ack_o), 64'd0);
      check("rst_busy",  64'(busy_o), 64'd0);
    end
    bus.req_sel_i      = '0;
    bus.req_wr_i       = '0;
    bus.req_mask_i     = '0;
    bus.req_addr_i     = '0;
    bus.req_data_out_i = '0;
    bus.vram_ack_i     = 1'b0;
    bus.vram_data_in_i = '0;
    tick();
    reset_ni = 1'b1;
    tick();

    // 2: req0 write, ack in 4th busy cycle; payload changes during BUSY must not leak
    set_req(0, 1'b1, 4'h3, 32'h10, 16'hBEEF);
    bus.req_sel_i[0] = 1'b1;
    push(0, 1'b1, 4'h3, 32'h10, 16'hBEEF);
    wait_grant("t2", 8);
    set_req(0, 1'b0, 4'hC, 32'h99, 16'h5555);
    run_txn("t2", 4, 16'h0, 2'b01, 2'b01, wr_cnt);
    check("t2_wr_cycles", 64'(wr_cnt), 64'd4);

    // 4: req1 read, drops sel mid-transaction, still acked with read data
    set_req(1, 1'b0, 4'hF, 32'h20, 16'h0);
    bus.req_sel_i[1] = 1'b1;
    push(1, 1'b0, 4'hF, 32'h20, 16'h0);
    wait_grant("t4", 8);
    bus.req_sel_i[1] = 1'b0;
    run_txn("t4", 2, 16'h1234, 2'b10, 2'b00, wr_cnt);
    check("t4_wr_cycles", 64'(wr_cnt), 64'd0);

    // 3: both requesters continuously: strict rotation 0,1,0,1
    set_req(0, 1'b1, 4'h1, 32'h100, 16'hA0A0);
    set_req(1, 1'b1, 4'h2, 32'h200, 16'hB1B1);
    bus.req_sel_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push(0, 1'b1, 4'h1, 32'h100, 16'hA0A0);
      else            push(1, 1'b1, 4'h2, 32'h200, 16'hB1B1);
    end
    for (int k = 0; k < 4; k++) begin
      logic [1:0] ack_v;
      logic [1:0] drop_v;
      ack_v  = (k % 2 == 0) ? 2'b01 : 2'b10;
      drop_v = (k >= 2) ? ack_v : 2'b00;
      wait_grant($sformatf("t3_%0d", k), 8);
      run_txn($sformatf("t3_%0d", k), 1 + k, 16'(k), ack_v, drop_v, wr_cnt);
      check($sformatf("t3_%0d_wr_cycles", k), 64'(wr_cnt), 64'(1 + k));
    end

    // 5: ack while IDLE is ignored
    bus.vram_ack_i = 1'b1;
    #1;
    check("t5_ack",  64'(bus.req_ack_o), 64'd0);
    check("t5_busy", 64'(busy_o), 64'd0);
    tick();
    bus.vram_ack_i = 1'b0;
    check("t5_busy2", 64'(busy_o), 64'd0);
    check("t5_sel",   64'(bus.vram_sel_o), 64'd0);
    check("t5_grant", 64'(grant_o), 64'd1);

    // 6: reset mid-BUSY, late ack ignored, then priority restarts at requester 0
    set_req(0, 1'b1, 4'h5, 32'h300, 16'hC3C3);
    bus.req_sel_i[0] = 1'b1;
    push(0, 1'b1, 4'h5, 32'h300, 16'hC3C3);
    wait_grant("t6", 8);
    tick();
    #2;
    reset_ni = 1'b0;
    #1;
    check("t6_rst_sel",   64'(bus.vram_sel_o), 64'd0);
    check("t6_rst_busy",  64'(busy_o), 64'd0);
    check("t6_rst_wr",    64'(bus.vram_wr_o), 64'd0);
    check("t6_rst_mask",  64'(bus.vram_mask_o), 64'hF);
    check("t6_rst_grant", 64'(grant_o), 64'd1);
    bus.req_sel_i  = 2'b00;
    bus.vram_ack_i = 1'b1;
    #1;
    check("t6_rst_ack", 64'(bus.req_ack_o), 64'd0);
    tick();
    bus.vram_ack_i = 1'b0;
    reset_ni = 1'b1;
    tick();
    bus.vram_ack_i = 1'b1;
    #1;
    check("t6_late_ack",  64'(bus.req_ack_o), 64'd0);
    tick();
    bus.vram_ack_i = 1'b0;
    check("t6_late_sel",  64'(bus.vram_sel_o), 64'd0);
    check("t6_late_busy", 64'(busy_o), 64'd0);
    set_req(0, 1'b0, 4'h7, 32'h300, 16'h0);
    set_req(1, 1'b1, 4'h8, 32'h400, 16'hD4D4);
    bus.req_sel_i = 2'b11;
    push(0, 1'b0, 4'h7, 32'h300, 16'h0);
    push(1, 1'b1, 4'h8, 32'h400, 16'hD4D4);
    wait_grant("t6a", 8);
    run_txn("t6a", 2, 16'h4321, 2'b01, 2'b01, wr_cnt);
    wait_grant("t6b", 8);
    run_txn("t6b", 1, 16'h0, 2'b10, 2'b10, wr_cnt);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
